// File: rtl/sdram_model.sv
// sdram_model: cycle-based behavioural model of an SDR SDRAM device.
// Four banks, JEDEC command decode, mode register, sequential/interleaved
// bursts with CAS latency 2/3 and per-byte DQM masking on reads and writes.
module sdram_model #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 12,
    parameter int ROW_BITS  = 12,
    parameter int COL_BITS  = 8,
    parameter int DM_BITS   = DATA_BITS / 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Cke,
    input  logic                 Cs_n,
    input  logic                 Ras_n,
    input  logic                 Cas_n,
    input  logic                 We_n,
    input  logic [1:0]           Ba,
    input  logic [ADDR_BITS-1:0] Addr,
    input  logic [DM_BITS-1:0]   Dqm,
    inout  wire  [DATA_BITS-1:0] Dq
);

    localparam logic [2:0] CMD_NOP    = 3'b111;
    localparam logic [2:0] CMD_ACTIVE = 3'b011;
    localparam logic [2:0] CMD_READ   = 3'b101;
    localparam logic [2:0] CMD_WRITE  = 3'b100;
    localparam logic [2:0] CMD_BST    = 3'b110;
    localparam logic [2:0] CMD_PRE    = 3'b010;
    localparam logic [2:0] CMD_REF    = 3'b001;
    localparam logic [2:0] CMD_LMR    = 3'b000;

    localparam int MEM_AW    = 2 + ROW_BITS + COL_BITS;
    localparam int MEM_WORDS = 1 << MEM_AW;

    logic [DATA_BITS-1:0] mem [0:MEM_WORDS-1];

    logic [2:0]           cmd;
    logic [ADDR_BITS-1:0] mode_reg;
    logic [COL_BITS-1:0]  mode_mask;
    logic                 mode_full;
    logic                 mode_cl2;
    logic [3:0]           bank_active;
    logic [ROW_BITS-1:0]  bank_row [4];

    logic                 burst_on, burst_wr, burst_ilv, burst_full, burst_ap;
    logic [1:0]           burst_ba;
    logic [ROW_BITS-1:0]  burst_row;
    logic [COL_BITS-1:0]  burst_start, burst_mask, burst_beat;
    logic                 ap_pend;
    logic [1:0]           ap_bank;

    logic                 rw_hit, new_wr, new_single, new_last;
    logic [COL_BITS-1:0]  new_mask;
    logic                 stop_burst, cont_burst, cont_last;
    logic                 beat_go, beat_wr, rd_go, wr_en;
    logic [1:0]           beat_ba;
    logic [ROW_BITS-1:0]  beat_row;
    logic [COL_BITS-1:0]  beat_col;
    logic [MEM_AW-1:0]    beat_addr;
    logic [DATA_BITS-1:0] rd_word;

    logic                 p0_valid, p1_valid;
    logic [DATA_BITS-1:0] p0_data, p1_data, out_data;
    logic [DM_BITS-1:0]   out_en, dqm_d;
    logic                 unused_mode;

    function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] start,
                                                      input logic [COL_BITS-1:0] mask,
                                                      input logic [COL_BITS-1:0] beat,
                                                      input logic                ilv);
        logic [COL_BITS-1:0] low;
        low = ilv ? (start ^ beat) : (start + beat);
        return (start & ~mask) | (low & mask);
    endfunction

    assign cmd         = (Cke && !Cs_n) ? {Ras_n, Cas_n, We_n} : CMD_NOP;
    assign mode_full   = (mode_reg[2:0] == 3'b111);
    assign mode_cl2    = (mode_reg[6:4] == 3'd2);
    assign unused_mode = ^{mode_reg[ADDR_BITS-1:10], mode_reg[8:7]};

    // Burst length field turned into a column wrap mask; reserved codes act as BL1
    always_comb begin
        mode_mask = '0;
        case (mode_reg[2:0])
            3'b001:  mode_mask = COL_BITS'(1);
            3'b010:  mode_mask = COL_BITS'(3);
            3'b011:  mode_mask = COL_BITS'(7);
            3'b111:  mode_mask = '1;
            default: mode_mask = '0;
        endcase
    end

    assign new_wr     = (cmd == CMD_WRITE);
    assign rw_hit     = ((cmd == CMD_READ) || new_wr) && bank_active[Ba];
    assign new_single = new_wr && mode_reg[9];
    assign new_mask   = new_single ? '0 : mode_mask;
    assign new_last   = (new_mask == '0);
    assign stop_burst = (cmd == CMD_BST) || ((cmd == CMD_PRE) && (Addr[10] || (Ba == burst_ba)));
    assign cont_burst = burst_on && !rw_hit && !stop_burst;
    assign cont_last  = !burst_full && (burst_beat == burst_mask);

    // Select the beat serviced at this edge: a fresh READ/WRITE wins over a running burst
    always_comb begin
        beat_go  = rw_hit || cont_burst;
        beat_wr  = burst_wr;
        beat_ba  = burst_ba;
        beat_row = burst_row;
        beat_col = burst_col(burst_start, burst_mask, burst_beat, burst_ilv);
        if (rw_hit) begin
            beat_wr  = new_wr;
            beat_ba  = Ba;
            beat_row = bank_row[Ba];
            beat_col = Addr[COL_BITS-1:0];
        end
    end

    assign beat_addr = {beat_ba, beat_row, beat_col};
    assign rd_word   = mem[beat_addr];
    assign rd_go     = beat_go && !beat_wr;
    assign wr_en     = !Rst && Cke && beat_go && beat_wr;

    // Array write with per-lane masking; contents deliberately survive reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int l = 0; l < DM_BITS; l++) begin
                if (!Dqm[l]) begin
                    mem[beat_addr][l*8 +: 8] <= Dq[l*8 +: 8];
                end
            end
        end
    end

    // Mode register and per-bank open/closed state, including delayed auto-precharge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_reg    <= ADDR_BITS'(12'h030);
            bank_active <= '0;
        end else if (Cke) begin
            if (ap_pend) begin
                bank_active[ap_bank] <= 1'b0;
            end
            case (cmd)
                CMD_ACTIVE: begin
                    bank_active[Ba] <= 1'b1;
                    bank_row[Ba]    <= Addr[ROW_BITS-1:0];
                end
                CMD_PRE: begin
                    if (Addr[10]) begin
                        bank_active <= '0;
                    end else begin
                        bank_active[Ba] <= 1'b0;
                    end
                end
                CMD_LMR:                            mode_reg <= Addr;
                CMD_NOP, CMD_REF, CMD_BST,
                CMD_READ, CMD_WRITE:                ;
                default:                            ;
            endcase
        end
    end

    // Burst sequencer: latch a new burst, step the beat counter, or stop on BST/PRECHARGE
    always_ff @(posedge Clk) begin
        if (Rst) begin
            burst_on <= 1'b0;
            ap_pend  <= 1'b0;
        end else if (Cke) begin
            ap_pend <= 1'b0;
            if (rw_hit) begin
                burst_on    <= !new_last;
                burst_wr    <= new_wr;
                burst_ba    <= Ba;
                burst_row   <= bank_row[Ba];
                burst_start <= Addr[COL_BITS-1:0];
                burst_mask  <= new_mask;
                burst_ilv   <= mode_reg[3] && !mode_full;
                burst_full  <= mode_full && !new_single;
                burst_ap    <= Addr[10];
                burst_beat  <= COL_BITS'(1);
                ap_pend     <= new_last && Addr[10];
                ap_bank     <= Ba;
            end else if (cont_burst) begin
                burst_beat <= burst_beat + COL_BITS'(1);
                if (cont_last) begin
                    burst_on <= 1'b0;
                    ap_pend  <= burst_ap;
                    ap_bank  <= burst_ba;
                end
            end else if (stop_burst) begin
                burst_on <= 1'b0;
            end
        end
    end

    // CAS latency pipeline: CL3 enters at stage 0, CL2 skips straight to stage 1
    always_ff @(posedge Clk) begin
        if (Rst) begin
            p0_valid <= 1'b0;
            p1_valid <= 1'b0;
            out_en   <= '0;
            dqm_d    <= '0;
        end else if (Cke) begin
            dqm_d    <= Dqm;
            p0_valid <= rd_go && !mode_cl2;
            p0_data  <= rd_word;
            p1_valid <= p0_valid;
            p1_data  <= p0_data;
            if (rd_go && mode_cl2) begin
                p1_valid <= 1'b1;
                p1_data  <= rd_word;
            end
            out_data <= p1_data;
            out_en   <= p1_valid ? ~dqm_d : '0;
        end
    end

    for (genvar l = 0; l < DM_BITS; l++) begin : g_lane
        assign Dq[l*8 +: 8] = out_en[l] ? out_data[l*8 +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: directed scoreboard bench for sdram_model (32-bit device).
// Stimulus queues the bus value expected at a given edge; a monitor compares
// at the falling edge before that edge. A released bus reads as all ones
// through the pull-ups, so a Z lane is expected as 8'hFF.
module tb_sdram_model;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] BST = 3'b110;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] LMR = 3'b000;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    typedef struct packed {
        int          at_edge;
        logic [31:0] data;
        logic [95:0] tag;
    } exp_t;

    logic        clk;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [3:0]  dqm;
    logic        tb_drive;
    logic [31:0] tb_data;
    wire  [31:0] dq_bus;

    int          edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;
    exp_t        exp_q[$];
    logic [31:0] wdata [8];
    logic [31:0] edata [8];
    int          t0;

    assign dq_bus = tb_drive ? tb_data : 32'hz;
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup (dq_bus[i]);
    end

    sdram_model #(.DATA_BITS(32), .ADDR_BITS(12), .ROW_BITS(12), .COL_BITS(8), .DM_BITS(4)) dut (
        .Clk(clk), .Rst(rst), .Cke(cke), .Cs_n(cs_n), .Ras_n(ras_n), .Cas_n(cas_n),
        .We_n(we_n), .Ba(ba), .Addr(addr), .Dqm(dqm), .Dq(dq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can name the edge they belong to
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compare every expectation due at the next edge, flag any that slipped past
    always @(negedge clk) begin : monitor
        int target;
        target = edge_cnt + 1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at_edge == target) begin
                checks++;
                if (dq_bus !== exp_q[i].data) begin
                    errors++;
                    $display("[TB] FAIL %0s @edge %0d: got %08h expected %08h",
                             exp_q[i].tag, target, dq_bus, exp_q[i].data);
                end
                exp_q.delete(i);
            end else if (exp_q[i].at_edge < target) begin
                checks++;
                errors++;
                $display("[TB] FAIL %0s @edge %0d: got no sample expected %08h",
                         exp_q[i].tag, exp_q[i].at_edge, exp_q[i].data);
                exp_q.delete(i);
            end
        end
    end

    // Drive one command cycle; it is sampled at edge edge_cnt+1
    task automatic apply_stimulus(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                                  input logic [3:0] m, input logic drv, input logic [31:0] d);
        @(posedge clk);
        #2;
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        dqm = m;
        tb_drive = drv;
        tb_data = d;
    endtask

    task automatic check_output(input int at, input logic [31:0] d, input logic [95:0] tag);
        exp_t e;
        e.at_edge = at;
        e.data = d;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic cmd_cycle(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
        apply_stimulus(c, b, a, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cmd_cycle(NOP, 2'd0, 12'd0);
    endtask

    task automatic write_burst(input logic [1:0] b, input logic [11:0] a, input int n, input logic [3:0] m);
        for (int i = 0; i < n; i++) apply_stimulus((i == 0) ? WR : NOP, b, a, m, 1'b1, wdata[i]);
        cmd_cycle(NOP, 2'd0, 12'd0);
    endtask

    // READ with CL3: bus idle at T0+2, n beats from T0+3, idle right after
    task automatic read_check(input logic [1:0] b, input logic [11:0] a, input int n, input logic [95:0] tag);
        int rt0;
        apply_stimulus(RD, b, a, 4'h0, 1'b0, 32'h0);
        rt0 = edge_cnt + 1;
        check_output(rt0 + 2, IDLE, tag);
        for (int i = 0; i < n; i++) check_output(rt0 + 3 + i, edata[i], tag);
        check_output(rt0 + 3 + n, IDLE, tag);
        idle(n + 6);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
        ba = 2'd0; addr = 12'd0; dqm = 4'h0; tb_drive = 1'b0; tb_data = 32'h0;

        // Reset: bus released, all banks closed
        check_output(2, IDLE, "rst_bus");
        check_output(3, IDLE, "rst_bus");
        idle(3);
        rst = 1'b0;
        read_check(2'd0, 12'd0, 0, "rst_bank");

        // BL8 sequential CL3 write then read of the same burst
        cmd_cycle(LMR, 2'd0, 12'h033);
        cmd_cycle(ACT, 2'd0, 12'd4);
        for (int i = 0; i < 8; i++) wdata[i] = 32'h1111_1111 * (i + 1);
        write_burst(2'd0, 12'd0, 8, 4'h0);
        for (int i = 0; i < 8; i++) edata[i] = 32'h1111_1111 * (i + 1);
        read_check(2'd0, 12'd0, 8, "seq_rd");

        // Sequential wrap: write from col 5 lands at 5,6,7,0,1,2,3,4
        for (int i = 0; i < 8; i++) wdata[i] = i;
        write_burst(2'd0, 12'd5, 8, 4'h0);
        edata[0] = 3; edata[1] = 4; edata[2] = 5; edata[3] = 6;
        edata[4] = 7; edata[5] = 0; edata[6] = 1; edata[7] = 2;
        read_check(2'd0, 12'd0, 8, "wrap_c0");
        for (int i = 0; i < 8; i++) edata[i] = i;
        read_check(2'd0, 12'd5, 8, "wrap_c5");

        // Interleaved: beat n of a col-5 write goes to col 5^n
        cmd_cycle(LMR, 2'd0, 12'h03B);
        cmd_cycle(ACT, 2'd1, 12'd7);
        for (int i = 0; i < 8; i++) wdata[i] = i;
        write_burst(2'd1, 12'd5, 8, 4'h0);
        edata[0] = 5; edata[1] = 4; edata[2] = 7; edata[3] = 6;
        edata[4] = 1; edata[5] = 0; edata[6] = 3; edata[7] = 2;
        read_check(2'd1, 12'd0, 8, "ilv_rd");

        // Write masking, BL1
        cmd_cycle(LMR, 2'd0, 12'h030);
        cmd_cycle(ACT, 2'd2, 12'd1);
        wdata[0] = 32'hFFFF_FFFF; write_burst(2'd2, 12'd9, 1, 4'h0);
        wdata[0] = 32'hAABB_CCDD; write_burst(2'd2, 12'd9, 1, 4'b0101);
        wdata[0] = 32'h1234_5678; write_burst(2'd2, 12'd10, 1, 4'h0);
        wdata[0] = 32'hAABB_CCDD; write_burst(2'd2, 12'd10, 1, 4'b0101);
        edata[0] = 32'hAAFF_CCFF; read_check(2'd2, 12'd9, 1, "wmask_ff");
        edata[0] = 32'hAA34_CC78; read_check(2'd2, 12'd10, 1, "wmask_bg");

        // Read masking, BL4: Dqm at edge k blanks the beat valid at k+2
        cmd_cycle(LMR, 2'd0, 12'h032);
        apply_stimulus(RD, 2'd0, 12'd0, 4'h0, 1'b0, 32'h0);
        t0 = edge_cnt + 1;
        check_output(t0 + 3, 32'h0000_0003, "rmask");
        check_output(t0 + 4, IDLE, "rmask");
        check_output(t0 + 5, 32'h0000_00FF, "rmask");
        check_output(t0 + 6, 32'h0000_0006, "rmask");
        check_output(t0 + 7, IDLE, "rmask");
        apply_stimulus(NOP, 2'd0, 12'd0, 4'h0, 1'b0, 32'h0);
        apply_stimulus(NOP, 2'd0, 12'd0, 4'hF, 1'b0, 32'h0);
        apply_stimulus(NOP, 2'd0, 12'd0, 4'h1, 1'b0, 32'h0);
        idle(8);

        // Read interrupted by a second read three cycles later
        cmd_cycle(LMR, 2'd0, 12'h033);
        apply_stimulus(RD, 2'd0, 12'd0, 4'h0, 1'b0, 32'h0);
        t0 = edge_cnt + 1;
        check_output(t0 + 2, IDLE, "rd_intr");
        check_output(t0 + 3, 32'd3, "rd_intr");
        check_output(t0 + 4, 32'd4, "rd_intr");
        check_output(t0 + 5, 32'd5, "rd_intr");
        for (int i = 0; i < 8; i++) check_output(t0 + 6 + i, (i + 7) % 8, "rd_intr");
        check_output(t0 + 14, IDLE, "rd_intr");
        idle(2);
        cmd_cycle(RD, 2'd0, 12'd4);
        idle(14);

        // Burst terminate two cycles after READ: only beats 0 and 1 appear
        apply_stimulus(RD, 2'd0, 12'd0, 4'h0, 1'b0, 32'h0);
        t0 = edge_cnt + 1;
        check_output(t0 + 3, 32'd3, "bst");
        check_output(t0 + 4, 32'd4, "bst");
        check_output(t0 + 5, IDLE, "bst");
        idle(1);
        cmd_cycle(BST, 2'd0, 12'd0);
        idle(10);

        // Auto-precharge read closes the bank; precharge-all closes the rest
        cmd_cycle(LMR, 2'd0, 12'h030);
        edata[0] = 32'hAAFF_CCFF;
        read_check(2'd2, 12'h409, 1, "ap_rd");
        read_check(2'd2, 12'h009, 0, "ap_closed");
        cmd_cycle(PRE, 2'd0, 12'h400);
        read_check(2'd0, 12'd0, 0, "pall_b0");
        read_check(2'd1, 12'd0, 0, "pall_b1");

        // Reset at beat 3 of a write burst
        cmd_cycle(LMR, 2'd0, 12'h033);
        cmd_cycle(ACT, 2'd3, 12'd2);
        for (int i = 0; i < 8; i++) wdata[i] = 32'h5A00_0000 + i;
        write_burst(2'd3, 12'd0, 8, 4'h0);
        for (int i = 0; i < 8; i++) wdata[i] = 32'h0000_00A0 + i;
        apply_stimulus(WR, 2'd3, 12'd0, 4'h0, 1'b1, wdata[0]);
        apply_stimulus(NOP, 2'd0, 12'd0, 4'h0, 1'b1, wdata[1]);
        apply_stimulus(NOP, 2'd0, 12'd0, 4'h0, 1'b1, wdata[2]);
        apply_stimulus(NOP, 2'd0, 12'd0, 4'h0, 1'b1, wdata[3]);
        rst = 1'b1;
        for (int i = 4; i < 8; i++) begin
            apply_stimulus(NOP, 2'd0, 12'd0, 4'h0, 1'b1, wdata[i]);
            rst = 1'b0;
        end
        cmd_cycle(NOP, 2'd0, 12'd0);
        read_check(2'd3, 12'd0, 0, "rst_closed");
        cmd_cycle(ACT, 2'd3, 12'd2);
        for (int c = 0; c < 8; c++) begin
            edata[0] = (c < 3) ? (32'h0000_00A0 + c) : (32'h5A00_0000 + c);
            read_check(2'd3, 12'(c), 1, "rst_wr");
        end

        idle(20);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
